spi_target: RTL and testbench
=============================

# spi_target

Synchronous SPI target (responder) that receives the 40-bit datagrams sent by the design's SPI initiator. It returns a preloaded 40-bit response on MISO. It serves as the on-chip stand-in for a stepper-driver register file, so firmware and SPI traffic can be exercised on the board without external drivers. All SPI pins are oversampled in the system clock domain; there is no logic clocked by SCK.

## Interface
Parameters:
- SIZE, 40, datagram length in bits, MSB first.
- SYNC_STAGES, 2, number of synchronizer flops on sck_in, cs_n_in and mosi_in (≥2).

Ports:
- clk_in, input, 1, system clock (25 MHz on the board).
- reset_in, input, 1, asynchronous, active-high reset.
- sck_in, input, 1, SPI clock; idle high (mode 3).
- cs_n_in, input, 1, chip select, active low.
- mosi_in, input, 1, serial data from the initiator.
- miso_out, output, 1, serial data to the initiator.
- miso_oe_out, output, 1, MISO drive enable; high while selected.
- tx_data_in, input, SIZE, response word; captured at frame start.
- rx_data_out, output, SIZE, last correctly framed received word.
- rx_valid_out, output, 1, one-cycle pulse when rx_data_out updates.
- frame_err_out, output, 1, one-cycle pulse on a frame with bit count ≠ SIZE.
- busy_out, output, 1, high while a frame is in progress.

## Operation
- Mode 3 protocol:
  - SCK idles high.
  - The target shifts MISO on each SCK falling edge.
  - The target samples MOSI on each SCK rising edge.
- Synchronizers: sck, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronized sck/cs_n samples.
- State IDLE:
  - Outputs: miso_oe_out=0, miso_out=0, busy_out=0.
  - On a cs_n falling edge:
    - tx_shift <= tx_data_in.
    - bit_cnt <= 0.
    - go to ACTIVE.
- State ACTIVE:
  - busy_out=1, miso_oe_out=1.
  - On an sck falling edge: miso_out <= tx_shift[SIZE-1], then tx_shift <= tx_shift << 1 with zero fill.
  - On an sck rising edge: rx_shift <= {rx_shift[SIZE-2:0], mosi_sync}. bit_cnt increments and saturates at SIZE+1.
  - On a cs_n rising edge, go to IDLE, then:
    - If bit_cnt == SIZE: rx_data_out <= rx_shift and pulse rx_valid_out.
    - Otherwise: pulse frame_err_out and leave rx_data_out unchanged.
- State WAIT_IDLE:
  - Entered from reset when synchronized cs_n is low.
  - Ignores all traffic until cs_n is seen high, then goes to IDLE.
  - Prevents a frame already under way at reset release from being decoded.
- bit_cnt width is clog2(SIZE+2). Saturation means any overrun (>SIZE bits) is reported as an error, never as a wrap to a valid count.
- Simultaneous events:
  - cs_n rising together with an sck edge: cs_n wins and the sck edge is ignored.
  - cs_n falling together with an sck edge: the frame starts and the sck edge is ignored.
- tx_data_in changes during ACTIVE have no effect on the current frame.

## Timing
- Reset values:
  - miso_out=0, miso_oe_out=0, busy_out=0.
  - rx_data_out=0, rx_valid_out=0, frame_err_out=0.
  - Internal shift registers are 0.
  - State = IDLE, or WAIT_IDLE if synchronized cs_n is low at the first clock after reset.
- Pin-to-action latency is SYNC_STAGES+1 clk_in cycles for every SCK and CS edge. This covers miso_out update, MOSI sample and frame start/end.
- rx_valid_out / frame_err_out rise SYNC_STAGES+1 cycles after cs_n rises and are high for exactly 1 cycle.
- Minimum SCK high time and low time is SYNC_STAGES+2 clk_in cycles. At 25 MHz with SYNC_STAGES=2 this gives SCK ≤ 3.1 MHz.
- Minimum CS-low to first SCK fall is SYNC_STAGES+2 cycles.
- Minimum last SCK rise to CS high is 2 cycles.
- Minimum CS high between frames is SYNC_STAGES+2 cycles.
- Reset is asynchronous on assertion. Reset asserted mid-frame drops the frame silently: no pulse, outputs go to reset values immediately.

## Test plan
1. Clean frame:
   - Stimulus: tx_data_in=40'hA5_1234_5678, MOSI sends 40'h80_DEAD_BEEF at SCK half-period 4 cycles.
   - Response: MISO bits on the 40 rising edges read back 40'hA5_1234_5678. rx_data_out=40'h80_DEAD_BEEF. Exactly one rx_valid_out pulse and no frame_err_out.
2. Short frame:
   - Stimulus: 39 SCK cycles, then CS high.
   - Response: frame_err_out pulses once, rx_valid_out stays 0, rx_data_out retains the previous value from scenario 1.
3. Long frame:
   - Stimulus: 41 SCK cycles.
   - Response: frame_err_out pulses and rx_data_out is unchanged.
4. Reset mid-frame and partial frame at release:
   - Stimulus: assert reset_in after bit 20 while CS is still low; release reset, clock 19 more bits, then CS high.
   - Response: all outputs read 0 from assertion, with no pulses. The next full 40-bit frame after CS high/low is received correctly.
5. Back-to-back frames:
   - Stimulus: two frames separated by a 4-cycle CS-high gap, with tx_data_in changed during frame 1.
   - Response: frame 1 MISO carries the old tx_data_in and frame 2 carries the new value. Two rx_valid_out pulses, each with the correct data.

Source files
------------

// File: rtl/spi_target_if.sv
// Signal bundle between the SPI target and its surroundings: SPI pins plus
// the parallel response/receive words and frame status.
interface spi_target_if #(
    parameter int SIZE = 40
);
    logic            sck_in;
    logic            cs_n_in;
    logic            mosi_in;
    logic            miso_out;
    logic            miso_oe_out;
    logic [SIZE-1:0] tx_data_in;
    logic [SIZE-1:0] rx_data_out;
    logic            rx_valid_out;
    logic            frame_err_out;
    logic            busy_out;

    // The target side of the link.
    modport slave (
        input  sck_in, cs_n_in, mosi_in, tx_data_in,
        output miso_out, miso_oe_out, rx_data_out, rx_valid_out,
        frame_err_out, busy_out
    );

    // The side that drives the SPI pins and consumes the results.
    modport master (
        output sck_in, cs_n_in, mosi_in, tx_data_in,
        input  miso_out, miso_oe_out, rx_data_out, rx_valid_out,
        frame_err_out, busy_out
    );
endinterface

// File: rtl/spi_target.sv
// Mode-3 SPI target with fixed-length datagrams, fully oversampled in the
// clk_in domain. Stands in for an external stepper-driver register file.
module spi_target #(
    parameter int SIZE        = 40,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk_in,
    input logic        reset_in,
    spi_target_if.slave bus
);
    localparam int               CNT_W    = $clog2(SIZE + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SIZE + 1);
    // Synchronizers come out of reset as {sck high, cs_n low, mosi 0}: the
    // link is assumed busy until cs_n is actually observed high.
    localparam logic [2:0]       SYNC_RST = 3'b100;

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_IDLE} state_t;

    logic [2:0] pins;
    assign pins = {bus.sck_in, bus.cs_n_in, bus.mosi_in};

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] stage_d;
        logic [2:0] stage_reg;
        if (gi == 0) begin : g_first
            assign stage_d = pins;
        end else begin : g_chain
            assign stage_d = g_sync[gi-1].stage_reg;
        end
        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) stage_reg <= SYNC_RST;
            else          stage_reg <= stage_d;
        end
    end

    logic sck_s, cs_s, mosi_s;
    assign {sck_s, cs_s, mosi_s} = g_sync[SYNC_STAGES-1].stage_reg;

    logic sck_prev_reg, cs_prev_reg;
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sck_prev_reg <= 1'b1;
            cs_prev_reg  <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_s;
        end
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign cs_rise  = cs_s & ~cs_prev_reg;
    assign cs_fall  = ~cs_s & cs_prev_reg;

    state_t           state_reg, state_next;
    logic [SIZE-1:0]  tx_shift_reg, tx_shift_next;
    logic [SIZE-1:0]  rx_shift_reg, rx_shift_next;
    logic [SIZE-1:0]  rx_data_reg, rx_data_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             miso_reg, miso_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Starting in WAIT_IDLE is equivalent to the IDLE/WAIT_IDLE choice: with
    // cs_n high the synchronized level reaches WAIT_IDLE's exit condition
    // before any frame could legally start.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg     <= WAIT_IDLE;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            bit_cnt_reg   <= '0;
            miso_reg      <= 1'b0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            bit_cnt_reg   <= bit_cnt_next;
            miso_reg      <= miso_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tx_shift_next  = tx_shift_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        bit_cnt_next   = bit_cnt_reg;
        miso_next      = miso_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_next = bus.tx_data_in;
                    bit_cnt_next  = '0;
                    miso_next     = 1'b0;
                    state_next    = ACTIVE;
                end
            end
            ACTIVE: begin
                // Deselect takes priority over any coincident SCK edge.
                if (cs_rise) begin
                    state_next = IDLE;
                    miso_next  = 1'b0;
                    if (bit_cnt_reg == CNT_FULL) begin
                        rx_data_next  = rx_shift_reg;
                        rx_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    if (sck_fall) begin
                        miso_next     = tx_shift_reg[SIZE-1];
                        tx_shift_next = {tx_shift_reg[SIZE-2:0], 1'b0};
                    end
                    if (sck_rise) begin
                        rx_shift_next = {rx_shift_reg[SIZE-2:0], mosi_s};
                        if (bit_cnt_reg != CNT_MAX)
                            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                if (cs_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.miso_out      = miso_reg;
    assign bus.miso_oe_out   = (state_reg == ACTIVE);
    assign bus.busy_out      = (state_reg == ACTIVE);
    assign bus.rx_data_out   = rx_data_reg;
    assign bus.rx_valid_out  = rx_valid_reg;
    assign bus.frame_err_out = frame_err_reg;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table of framed transfers plus hand-built
// reset-mid-frame and back-to-back sequences.
module tb_spi_target;
    localparam int SIZE = 40;
    localparam int H    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_target_if #(.SIZE(SIZE)) bus ();

    spi_target #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int tests  = 0;
    int failed = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    logic [SIZE-1:0] got_q[$];
    logic [SIZE-1:0] miso_cap;

    typedef struct {
        logic [SIZE-1:0] tx;
        logic [SIZE-1:0] mosi;
        int              nbits;
        int              exp_valid;
        int              exp_err;
        logic [SIZE-1:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    always @(negedge clk) begin
        if (bus.rx_valid_out) begin
            valid_cnt++;
            got_q.push_back(bus.rx_data_out);
        end
        if (bus.frame_err_out) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_start(input logic [SIZE-1:0] tx);
        bus.tx_data_in = tx;
        bus.cs_n_in    = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    // Bit i of the frame carries word[SIZE-1-i]; bits past SIZE send 0.
    task automatic spi_bits(input logic [SIZE-1:0] word, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            bus.sck_in  = 1'b0;
            bus.mosi_in = (i < SIZE) ? word[SIZE-1-i] : 1'b0;
            repeat (H) @(negedge clk);
            if (i < SIZE) miso_cap[SIZE-1-i] = bus.miso_out;
            bus.sck_in = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    // Raise CS and report how many cycles later the first status pulse shows.
    task automatic spi_end(output int lat);
        lat = -1;
        repeat (2) @(negedge clk);
        bus.cs_n_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((bus.rx_valid_out || bus.frame_err_out) && lat < 0) lat = k;
        end
    endtask

    initial begin
        int lat;
        logic [SIZE-1:0] ones, mask, cap1;

        vecs[0] = '{40'hA5_1234_5678, 40'h80_DEAD_BEEF, 40, 1, 0, 40'h80_DEAD_BEEF};
        vecs[1] = '{40'h11_2233_4455, 40'h01_2345_6789, 39, 0, 1, 40'h80_DEAD_BEEF};
        vecs[2] = '{40'h3C_C3F0_0F55, 40'hFF_FFFF_FFFF, 41, 0, 1, 40'h80_DEAD_BEEF};
        vecs[3] = '{40'h00_0000_0000, 40'h00_0000_0000,  0, 0, 1, 40'h80_DEAD_BEEF};
        vecs[4] = '{40'h00_0000_0001, 40'h7F_FFFF_FFFE, 40, 1, 0, 40'h7F_FFFF_FFFE};
        ones = '1;

        rst = 1'b1;
        bus.sck_in = 1'b1;
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        bus.tx_data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 64'(bus.rx_data_out), 64'h0);
        check("reset_pulses", {62'h0, bus.rx_valid_out, bus.frame_err_out}, 64'h0);
        check("reset_busy_oe_miso", {61'h0, bus.busy_out, bus.miso_oe_out, bus.miso_out}, 64'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_busy", 64'(bus.busy_out), 64'h0);

        for (int i = 0; i < 5; i++) begin
            valid_cnt = 0;
            err_cnt   = 0;
            miso_cap  = '0;
            spi_start(vecs[i].tx);
            if (i == 0) check("active_busy_oe", {62'h0, bus.busy_out, bus.miso_oe_out}, 64'h3);
            spi_bits(vecs[i].mosi, 0, vecs[i].nbits);
            spi_end(lat);
            mask = (vecs[i].nbits >= SIZE) ? ones : ~(ones >> vecs[i].nbits);
            if (vecs[i].nbits > 0)
                check($sformatf("v%0d_miso", i), 64'(miso_cap & mask), 64'(vecs[i].tx & mask));
            check($sformatf("v%0d_valid_cycles", i), 64'(valid_cnt), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d_err_cycles", i), 64'(err_cnt), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_rx_data", i), 64'(bus.rx_data_out), 64'(vecs[i].exp_rx));
            check($sformatf("v%0d_pulse_latency", i), 64'(lat), 64'(3));
            check($sformatf("v%0d_busy_after", i), 64'(bus.busy_out), 64'h0);
            $display("[TB] vec %0d bits=%0d miso=%h rx=%h valid=%0d err=%0d lat=%0d",
                     i, vecs[i].nbits, miso_cap, bus.rx_data_out, valid_cnt, err_cnt, lat);
        end

        // Reset in the middle of a frame, then finish that frame after release.
        valid_cnt = 0;
        err_cnt   = 0;
        spi_start(40'hCA_FEF0_0D12);
        spi_bits(40'h12_3456_789A, 0, 20);
        rst = 1'b1;
        #1;
        check("midrst_rx_data", 64'(bus.rx_data_out), 64'h0);
        check("midrst_busy_oe_miso", {61'h0, bus.busy_out, bus.miso_oe_out, bus.miso_out}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        spi_bits(40'h12_3456_789A, 20, 19);
        spi_end(lat);
        check("midrst_no_pulse", {32'(valid_cnt), 32'(err_cnt)}, 64'h0);
        check("midrst_rx_kept0", 64'(bus.rx_data_out), 64'h0);
        check("midrst_latency_none", 64'(lat), 64'(-1));
        $display("[TB] reset mid-frame: valid=%0d err=%0d rx=%h", valid_cnt, err_cnt, bus.rx_data_out);
        miso_cap = '0;
        spi_start(40'h5A_5A5A_5A5A);
        spi_bits(40'hC3_0F1E_2D3C, 0, 40);
        spi_end(lat);
        check("postrst_miso", 64'(miso_cap), 64'h5A_5A5A_5A5A);
        check("postrst_rx_data", 64'(bus.rx_data_out), 64'hC3_0F1E_2D3C);
        check("postrst_valid", {32'(valid_cnt), 32'(err_cnt)}, {32'd1, 32'd0});
        $display("[TB] post-reset frame: miso=%h rx=%h", miso_cap, bus.rx_data_out);

        // Back-to-back frames, response word changed mid-frame-1.
        valid_cnt = 0;
        err_cnt   = 0;
        got_q.delete();
        miso_cap  = '0;
        spi_start(40'h12_3456_789A);
        spi_bits(40'hAA_5500_FF11, 0, 20);
        bus.tx_data_in = 40'hFE_DCBA_9876;
        spi_bits(40'hAA_5500_FF11, 20, 20);
        cap1 = miso_cap;
        repeat (2) @(negedge clk);
        bus.cs_n_in = 1'b1;
        repeat (4) @(negedge clk);
        miso_cap = '0;
        spi_start(40'hFE_DCBA_9876);
        spi_bits(40'h01_0203_0405, 0, 40);
        spi_end(lat);
        check("b2b_f1_miso", 64'(cap1), 64'h12_3456_789A);
        check("b2b_f2_miso", 64'(miso_cap), 64'hFE_DCBA_9876);
        check("b2b_valid_cycles", {32'(valid_cnt), 32'(err_cnt)}, {32'd2, 32'd0});
        check("b2b_f1_rx", 64'((got_q.size() > 0) ? got_q[0] : 40'h0), 64'hAA_5500_FF11);
        check("b2b_f2_rx", 64'((got_q.size() > 1) ? got_q[1] : 40'h0), 64'h01_0203_0405);
        $display("[TB] back-to-back: f1 miso=%h f2 miso=%h pulses=%0d", cap1, miso_cap, valid_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
